// File: rtl/frog_game_controller.sv
// frog_game_controller
//   Game-state sequencer for the Frog Ranck VGA game. Consumes a per-frame
//   tick, a pixel-overlap collision flag and the player row, and sequences
//   IDLE/PLAY/HIT/WIN/OVER. Drives lives, level, score, player respawn,
//   move enable and a level-scaled car step strobe.
//
//   Ports:
//     CLK            in   pixel clock, all logic on posedge
//     RST_N          in   synchronous reset, active low
//     frame_tick     in   one-cycle pulse per frame (start of vblank)
//     start_btn      in   start button level, synchronous to CLK
//     collision      in   high on any cycle player and a car overlap
//     player_y       in   current player row (pixels)
//     game_state     out  0=IDLE 1=PLAY 2=HIT 3=WIN 4=OVER (FSM state, usable for debug)
//     lives          out  remaining lives
//     level          out  current level
//     score          out  frogs delivered, saturating at 255
//     player_respawn out  one-cycle pulse: reload player start position
//     move_enable    out  high only in PLAY
//     car_step       out  one-cycle pulse: cars advance one step
//     car_period     out  frames per car step for the current level
//
//   Pulse semantics: there is no valid/ready handshake here. frame_tick,
//   player_respawn and car_step are single-cycle strobes. Every output is
//   registered, so the response to inputs sampled at edge N is visible
//   right after edge N.
module frog_game_controller #(
  parameter int LIVES_INIT = 3,
  parameter int GOAL_Y     = 0,
  parameter int HIT_FRAMES = 60,
  parameter int WIN_FRAMES = 60,
  parameter int SPEED_INIT = 8,
  parameter int SPEED_MIN  = 2,
  parameter int MAX_LEVEL  = 15
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       collision,
  input  logic [9:0] player_y,
  output logic [2:0] game_state,
  output logic [1:0] lives,
  output logic [3:0] level,
  output logic [7:0] score,
  output logic       player_respawn,
  output logic       move_enable,
  output logic       car_step,
  output logic [3:0] car_period
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PLAY = 3'd1,
    ST_HIT  = 3'd2,
    ST_WIN  = 3'd3,
    ST_OVER = 3'd4
  } state_e;

  localparam logic [1:0] LIVES_L      = 2'(LIVES_INIT);
  localparam logic [9:0] GOAL_Y_L     = 10'(GOAL_Y);
  localparam logic [7:0] HIT_L        = 8'(HIT_FRAMES);
  localparam logic [7:0] WIN_L        = 8'(WIN_FRAMES);
  localparam logic [3:0] SPEED_INIT_L = 4'(SPEED_INIT);
  localparam logic [3:0] SPEED_MIN_L  = 4'(SPEED_MIN);
  localparam logic [3:0] MAX_LEVEL_L  = 4'(MAX_LEVEL);
  // Level at and beyond which the car period sits on its floor.
  localparam logic [3:0] FLOOR_LEVEL  = SPEED_INIT_L - SPEED_MIN_L;

  state_e     state_q,      state_d;
  logic [1:0] lives_q,      lives_d;
  logic [3:0] level_q,      level_d;
  logic [7:0] score_q,      score_d;
  logic [3:0] car_period_q, car_period_d;
  logic [7:0] timer_q,      timer_d;
  logic [3:0] frame_cnt_q,  frame_cnt_d;
  logic       respawn_q,    respawn_d;
  logic       car_step_q,   car_step_d;
  logic       move_en_q,    move_en_d;
  logic       hit_q,        hit_d;
  logic       start_prev_q, start_prev_d;

  logic       start_edge;
  logic [3:0] new_level;

  assign start_edge = start_btn & ~start_prev_q;

  always_comb begin
    state_d      = state_q;
    lives_d      = lives_q;
    level_d      = level_q;
    score_d      = score_q;
    car_period_d = car_period_q;
    timer_d      = timer_q;
    frame_cnt_d  = frame_cnt_q;
    respawn_d    = 1'b0;
    car_step_d   = 1'b0;
    hit_d        = hit_q;
    start_prev_d = start_btn;
    new_level    = (level_q == MAX_LEVEL_L) ? level_q : level_q + 4'd1;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_edge) begin
          state_d      = ST_PLAY;
          lives_d      = LIVES_L;
          level_d      = 4'd0;
          score_d      = 8'd0;
          car_period_d = SPEED_INIT_L;
          frame_cnt_d  = 4'd0;
          respawn_d    = 1'b1;
        end
      end

      ST_PLAY: begin
        if (frame_tick) begin
          // The latch covers one frame; a collision on the tick cycle itself
          // still counts for the frame that is ending.
          hit_d = 1'b0;
          if (hit_q || collision) begin
            state_d = ST_HIT;
            if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
            timer_d = HIT_L;
          end else if (player_y <= GOAL_Y_L) begin
            state_d = ST_WIN;
            if (score_q != 8'hFF) score_d = score_q + 8'd1;
            timer_d = WIN_L;
          end else if (frame_cnt_q == car_period_q - 4'd1) begin
            frame_cnt_d = 4'd0;
            car_step_d  = 1'b1;
          end else begin
            frame_cnt_d = frame_cnt_q + 4'd1;
          end
        end else if (collision) begin
          hit_d = 1'b1;
        end
      end

      ST_HIT: begin
        if (frame_tick) begin
          if (timer_q == 8'd1) begin
            // lives already reflects this hit, so zero means no frogs left.
            if (lives_q == 2'd0) begin
              state_d = ST_OVER;
            end else begin
              state_d     = ST_PLAY;
              respawn_d   = 1'b1;
              frame_cnt_d = 4'd0;
            end
          end else begin
            timer_d = timer_q - 8'd1;
          end
        end
      end

      ST_WIN: begin
        if (frame_tick) begin
          if (timer_q == 8'd1) begin
            level_d      = new_level;
            car_period_d = (new_level >= FLOOR_LEVEL) ? SPEED_MIN_L
                                                      : SPEED_INIT_L - new_level;
            respawn_d    = 1'b1;
            frame_cnt_d  = 4'd0;
            state_d      = ST_PLAY;
          end else begin
            timer_d = timer_q - 8'd1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    move_en_d = (state_d == ST_PLAY);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      lives_q      <= LIVES_L;
      level_q      <= 4'd0;
      score_q      <= 8'd0;
      car_period_q <= SPEED_INIT_L;
      timer_q      <= 8'd0;
      frame_cnt_q  <= 4'd0;
      respawn_q    <= 1'b0;
      car_step_q   <= 1'b0;
      move_en_q    <= 1'b0;
      hit_q        <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lives_q      <= lives_d;
      level_q      <= level_d;
      score_q      <= score_d;
      car_period_q <= car_period_d;
      timer_q      <= timer_d;
      frame_cnt_q  <= frame_cnt_d;
      respawn_q    <= respawn_d;
      car_step_q   <= car_step_d;
      move_en_q    <= move_en_d;
      hit_q        <= hit_d;
      start_prev_q <= start_prev_d;
    end
  end

  assign game_state     = state_q;
  assign lives          = lives_q;
  assign level          = level_q;
  assign score          = score_q;
  assign car_period     = car_period_q;
  assign player_respawn = respawn_q;
  assign car_step       = car_step_q;
  assign move_enable    = move_en_q;

endmodule
